// File: rtl/us_burst_ctrl_pkg.sv
// Shared definitions for the ultrasound burst controller: command codes,
// sequencer states and the shot counter width.
package us_ctrl_pkg;

    localparam logic [2:0] CMD_SINGLE = 3'b001;
    localparam logic [2:0] CMD_CONT   = 3'b010;
    localparam logic [2:0] CMD_STOP   = 3'b100;

    localparam int SHOT_CNT_W = 16;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        BURST  = 3'd1,
        BLANK  = 3'd2,
        LISTEN = 3'd3,
        WAIT   = 3'd4
    } state_t;

endpackage

// File: rtl/us_burst_ctrl_if.sv
// Command input and transducer/receive-path outputs of the burst controller.
// master: the command source / observer side, slave: the controller.
interface us_burst_ctrl_if;
    import us_ctrl_pkg::*;

    logic                  rx_done;
    logic [2:0]            command;
    logic                  tx_p;
    logic                  tx_n;
    logic                  rx_gate;
    logic                  listen_start;
    logic                  busy;
    logic                  cont_mode;
    logic [SHOT_CNT_W-1:0] shot_cnt;

    modport master (
        output rx_done, command,
        input  tx_p, tx_n, rx_gate, listen_start, busy, cont_mode, shot_cnt
    );

    modport slave (
        input  rx_done, command,
        output tx_p, tx_n, rx_gate, listen_start, busy, cont_mode, shot_cnt
    );

endinterface

// File: rtl/us_burst_ctrl_chk.sv
// Safety checks on the transducer drive pair.
module us_burst_ctrl_chk (
    input logic clk,
    input logic rst_n,
    input logic tx_p,
    input logic tx_n
);

    // Both bridge legs must never be driven at once.
    property p_drive_exclusive;
        @(posedge clk) disable iff (!rst_n) !(tx_p && tx_n);
    endproperty

    a_drive_exclusive: assert property (p_drive_exclusive);

endmodule

// File: rtl/us_burst_ctrl_pulse_gen.sv
// Complementary excitation generator. While enabled it walks through
// 2*BURST_CYCLES half-periods (P first), holding the active drive low for the
// first DEAD_CLKS clocks of every half. done marks the last emitted clock.
module us_pulse_gen #(
    parameter int HALF_CLKS    = 625,
    parameter int DEAD_CLKS    = 10,
    parameter int BURST_CYCLES = 8
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr,
    input  logic en,
    output logic tx_p,
    output logic tx_n,
    output logic done
);

    localparam int HW = $clog2(HALF_CLKS + 1);
    localparam int NW = $clog2(2 * BURST_CYCLES + 1);

    // Counters hold the position that will be emitted at the next enabled edge.
    logic [HW-1:0] h_r;
    logic [NW-1:0] half_r;
    logic          tx_p_r;
    logic          tx_n_r;
    logic          done_r;

    logic last_h_s;
    logic last_half_s;
    logic drive_s;

    // Decode the position about to be emitted.
    always_comb begin
        last_h_s    = (h_r == HW'(HALF_CLKS - 1));
        last_half_s = (half_r == NW'(2 * BURST_CYCLES - 1));
        drive_s     = (h_r >= HW'(DEAD_CLKS));
    end

    // Advance the half-period position and register the drive outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            h_r    <= '0;
            half_r <= '0;
            tx_p_r <= 1'b0;
            tx_n_r <= 1'b0;
            done_r <= 1'b0;
        end else if (clr) begin
            h_r    <= '0;
            half_r <= '0;
            tx_p_r <= 1'b0;
            tx_n_r <= 1'b0;
            done_r <= 1'b0;
        end else if (en) begin
            tx_p_r <= drive_s && !half_r[0];
            tx_n_r <= drive_s && half_r[0];
            done_r <= last_h_s && last_half_s;
            if (last_h_s) begin
                h_r    <= '0;
                half_r <= last_half_s ? '0 : half_r + NW'(1);
            end else begin
                h_r    <= h_r + HW'(1);
            end
        end else begin
            tx_p_r <= 1'b0;
            tx_n_r <= 1'b0;
            done_r <= 1'b0;
        end
    end

    assign tx_p = tx_p_r;
    assign tx_n = tx_n_r;
    assign done = done_r;

endmodule

// File: rtl/us_burst_ctrl.sv
// Ultrasound shot sequencer: decodes UART commands and runs
// BURST -> BLANK -> LISTEN (-> WAIT) shots, single or periodic.
module us_burst_ctrl
    import us_ctrl_pkg::*;
#(
    parameter int HALF_CLKS    = 625,
    parameter int DEAD_CLKS    = 10,
    parameter int BURST_CYCLES = 8,
    parameter int BLANK_CLKS   = 2500,
    parameter int LISTEN_CLKS  = 50000,
    parameter int PERIOD_CLKS  = 500000
) (
    input  logic           clk_50M,
    input  logic           rst_n,
    us_burst_ctrl_if.slave bus
);

    state_t                state_r;
    state_t                next_s;
    logic                  cont_r;
    logic                  cont_next_s;
    logic [31:0]           tmr_r;
    logic [31:0]           per_r;
    logic [SHOT_CNT_W-1:0] shot_cnt_r;
    logic                  rx_gate_r;
    logic                  listen_start_r;
    logic                  busy_r;
    logic                  cmd_single_s;
    logic                  cmd_cont_s;
    logic                  cmd_stop_s;
    logic                  pg_done_s;
    logic                  pg_en_s;
    logic                  pg_clr_s;

    // Command decode and next-state selection; STOP overrides everything.
    always_comb begin
        cmd_single_s = bus.rx_done && (bus.command == CMD_SINGLE);
        cmd_cont_s   = bus.rx_done && (bus.command == CMD_CONT);
        cmd_stop_s   = bus.rx_done && (bus.command == CMD_STOP);
        next_s       = state_r;
        cont_next_s  = cont_r;
        if (cmd_stop_s) begin
            next_s      = IDLE;
            cont_next_s = 1'b0;
        end else begin
            if (cmd_cont_s) begin
                cont_next_s = 1'b1;
            end else begin
                cont_next_s = cont_r;
            end
            case (state_r)
                IDLE:   next_s = (cmd_single_s || cmd_cont_s) ? BURST : IDLE;
                BURST:  next_s = pg_done_s ? BLANK : BURST;
                BLANK:  next_s = (tmr_r == 32'(BLANK_CLKS - 1)) ? LISTEN : BLANK;
                LISTEN: begin
                    if (tmr_r != 32'(LISTEN_CLKS - 1)) begin
                        next_s = LISTEN;
                    end else if (!cont_r) begin
                        next_s = IDLE;
                    end else if (per_r >= 32'(PERIOD_CLKS - 1)) begin
                        // Shot already fills the period: restart without WAIT.
                        next_s = BURST;
                    end else begin
                        next_s = WAIT;
                    end
                end
                WAIT:   next_s = (per_r >= 32'(PERIOD_CLKS - 1)) ? BURST : WAIT;
                default: next_s = IDLE;
            endcase
        end
        pg_en_s  = (next_s == BURST);
        pg_clr_s = (next_s != BURST);
    end

    // Sequencer state, timers, shot counter and registered status outputs.
    always_ff @(posedge clk_50M or negedge rst_n) begin
        if (!rst_n) begin
            state_r        <= IDLE;
            cont_r         <= 1'b0;
            tmr_r          <= 32'd0;
            per_r          <= 32'd0;
            shot_cnt_r     <= '0;
            rx_gate_r      <= 1'b0;
            listen_start_r <= 1'b0;
            busy_r         <= 1'b0;
        end else begin
            state_r        <= next_s;
            cont_r         <= cont_next_s;
            tmr_r          <= (next_s != state_r) ? 32'd0 : tmr_r + 32'd1;
            if ((next_s == BURST) && (state_r != BURST)) begin
                per_r      <= 32'd0;
                shot_cnt_r <= shot_cnt_r + SHOT_CNT_W'(1);
            end else begin
                per_r      <= per_r + 32'd1;
            end
            rx_gate_r      <= (next_s == LISTEN);
            listen_start_r <= (next_s == LISTEN) && (state_r != LISTEN);
            busy_r         <= (next_s != IDLE);
        end
    end

    us_pulse_gen #(
        .HALF_CLKS    (HALF_CLKS),
        .DEAD_CLKS    (DEAD_CLKS),
        .BURST_CYCLES (BURST_CYCLES)
    ) u_pulse_gen (
        .clk   (clk_50M),
        .rst_n (rst_n),
        .clr   (pg_clr_s),
        .en    (pg_en_s),
        .tx_p  (bus.tx_p),
        .tx_n  (bus.tx_n),
        .done  (pg_done_s)
    );

    us_burst_ctrl_chk u_chk (
        .clk   (clk_50M),
        .rst_n (rst_n),
        .tx_p  (bus.tx_p),
        .tx_n  (bus.tx_n)
    );

    assign bus.rx_gate      = rx_gate_r;
    assign bus.listen_start = listen_start_r;
    assign bus.busy         = busy_r;
    assign bus.cont_mode    = cont_r;
    assign bus.shot_cnt     = shot_cnt_r;

endmodule

// File: tb/tb_us_burst_ctrl.sv
// Bench for us_burst_ctrl: directed scenarios plus random commands, every
// cycle compared against a shot-timeline model built from offsets within a shot.
module tb_us_burst_ctrl;
    import us_ctrl_pkg::*;

    localparam int HALF  = 10;
    localparam int DEAD  = 2;
    localparam int BC    = 3;
    localparam int BL    = 20;
    localparam int LI    = 50;
    localparam int PER   = 200;
    localparam int BLEN  = 2 * HALF * BC;
    localparam int SHOT  = BLEN + BL + LI;
    localparam int CYC   = (SHOT > PER) ? SHOT : PER;

    logic clk_50M = 1'b0;
    logic rst_n;

    us_burst_ctrl_if bus();

    us_burst_ctrl #(
        .HALF_CLKS    (HALF),
        .DEAD_CLKS    (DEAD),
        .BURST_CYCLES (BC),
        .BLANK_CLKS   (BL),
        .LISTEN_CLKS  (LI),
        .PERIOD_CLKS  (PER)
    ) dut (
        .clk_50M (clk_50M),
        .rst_n   (rst_n),
        .bus     (bus)
    );

    always #10 clk_50M = ~clk_50M;

    int errors = 0;
    int checks = 0;

    // Reference model: is a shot sequence running, when did the current shot start.
    bit          m_active;
    bit          m_cont;
    int          m_start;
    logic [15:0] m_cnt;
    int          cyc;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    // Expected outputs for the current cycle from its offset within the shot.
    task automatic check_cycle();
        int o;
        bit ep, en, eg, els, eb;
        ep = 1'b0; en = 1'b0; eg = 1'b0; els = 1'b0; eb = 1'b0;
        if (m_active) begin
            o  = cyc - m_start;
            eb = 1'b1;
            if (o < BLEN) begin
                ep = ((o / HALF) % 2 == 0) && ((o % HALF) >= DEAD);
                en = ((o / HALF) % 2 == 1) && ((o % HALF) >= DEAD);
            end else if (o >= BLEN + BL && o < SHOT) begin
                eg  = 1'b1;
                els = (o == BLEN + BL);
            end
        end
        check_eq("tx_p", bus.tx_p, ep);
        check_eq("tx_n", bus.tx_n, en);
        check_eq("excl", bus.tx_p & bus.tx_n, 1'b0);
        check_eq("rx_gate", bus.rx_gate, eg);
        check_eq("listen_start", bus.listen_start, els);
        check_eq("busy", bus.busy, eb);
        check_eq("cont_mode", bus.cont_mode, m_cont);
        check_eq("shot_cnt", bus.shot_cnt, m_cnt);
    endtask

    // Apply this cycle's command and timeline progress to get the next cycle.
    task automatic model_advance(input bit rxd, input logic [2:0] cmd);
        int o;
        bit was_cont;
        if (rxd && cmd == CMD_STOP) begin
            m_active = 1'b0;
            m_cont   = 1'b0;
        end else begin
            was_cont = m_cont;
            if (rxd && cmd == CMD_CONT) m_cont = 1'b1;
            if (m_active) begin
                o = cyc - m_start;
                if (o == SHOT - 1 && !was_cont) begin
                    m_active = 1'b0;
                end else if (o == CYC - 1) begin
                    m_start = cyc + 1;
                    m_cnt   = m_cnt + 16'd1;
                end
            end else if (rxd && (cmd == CMD_SINGLE || cmd == CMD_CONT)) begin
                m_active = 1'b1;
                m_start  = cyc + 1;
                m_cnt    = m_cnt + 16'd1;
            end
        end
    endtask

    task automatic step(input bit rxd, input logic [2:0] cmd);
        bus.rx_done = rxd;
        bus.command = cmd;
        @(negedge clk_50M);
        check_cycle();
        @(posedge clk_50M);
        model_advance(rxd, cmd);
        cyc++;
        #1;
        bus.rx_done = 1'b0;
        bus.command = 3'b000;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 3'b000);
    endtask

    logic [15:0] base;
    logic [2:0]  rcmd;

    initial begin
        rst_n       = 1'b0;
        bus.rx_done = 1'b0;
        bus.command = 3'b000;
        m_active = 1'b0; m_cont = 1'b0; m_start = 0; m_cnt = 16'd0; cyc = 0;
        @(posedge clk_50M);
        #1;
        idle(2);
        rst_n = 1'b1;
        idle(3);

        // Single shot with ignored codes and a SINGLE while busy.
        step(1'b1, CMD_SINGLE);
        idle(20);
        step(1'b1, CMD_SINGLE);
        step(1'b1, 3'b111);
        step(1'b1, 3'b000);
        idle(120);
        check_eq("s1_cnt", bus.shot_cnt, 16'd1);
        step(1'b1, 3'b111);
        step(1'b1, 3'b000);
        idle(2);

        // Continuous mode: starts at relative cycles 1, 201, 401.
        base = bus.shot_cnt;
        step(1'b1, CMD_CONT);
        idle(410);
        check_eq("s2_shots", 16'(bus.shot_cnt - base), 16'd3);
        step(1'b1, CMD_STOP);
        idle(10);

        // STOP in the middle of the second burst.
        base = bus.shot_cnt;
        step(1'b1, CMD_CONT);
        idle(214);
        step(1'b1, CMD_STOP);
        idle(300);
        check_eq("s3_shots", 16'(bus.shot_cnt - base), 16'd2);

        // Asynchronous reset in the middle of a P half-period.
        step(1'b1, CMD_SINGLE);
        idle(5);
        check_eq("pre_rst_txp", bus.tx_p, 1'b1);
        #3;
        rst_n = 1'b0;
        #1;
        check_eq("rst_async_txp", bus.tx_p, 1'b0);
        check_eq("rst_async_txn", bus.tx_n, 1'b0);
        m_active = 1'b0; m_cont = 1'b0; m_cnt = 16'd0;
        idle(3);
        rst_n = 1'b1;
        idle(2);
        step(1'b1, CMD_SINGLE);
        idle(140);
        check_eq("s5_cnt", bus.shot_cnt, 16'd1);

        // Shot counter wrap.
        force dut.shot_cnt_r = 16'hFFFF;
        #1;
        release dut.shot_cnt_r;
        m_cnt = 16'hFFFF;
        step(1'b1, CMD_SINGLE);
        idle(140);
        check_eq("s6_wrap", bus.shot_cnt, 16'h0000);

        // Random command traffic.
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 39) == 0) begin
                case ($urandom_range(0, 3))
                    0:       rcmd = CMD_SINGLE;
                    1:       rcmd = CMD_CONT;
                    2:       rcmd = CMD_STOP;
                    default: rcmd = 3'($urandom_range(0, 7));
                endcase
                step(1'b1, rcmd);
            end else begin
                step(1'b0, 3'b000);
            end
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
